// File: rtl/c2_pkg.sv
// c2_pkg: shared constants, command and state enums for the C2 initiator.
// Optional response watchdog is enabled by defining C2_TIMEOUT_EN.
package c2_pkg;

    localparam int MEM_ADDR_SIZE     = 19;
    localparam int CACHE_OFFSET_SIZE = 4;
    localparam int BUS_SIZE          = 16;
    localparam int CACHE_LINE_SIZE   = 16;
    localparam int TIMEOUT_CYCLES    = 64;

    localparam int LINE_ADDR_W = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
    localparam int LINE_W      = CACHE_LINE_SIZE * 8;
    localparam int BEATS       = LINE_W / BUS_SIZE;
    localparam int BEAT_W      = $clog2(BEATS);

    typedef enum logic [1:0] {
        C2_NOP      = 2'd0,
        C2_RESPONSE = 2'd1,
        C2_READ     = 2'd2,
        C2_WRITE    = 2'd3
    } c2_cmd_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_BEAT,
        S_WAIT_WACK,
        S_RD_CMD,
        S_WAIT_RDATA,
        S_DONE
    } c2_state_e;

endpackage

// File: rtl/c2_line_serdes.sv
// c2_line_serdes: line shift register (load / shift-out / shift-in)
// with the 3-bit beat counter; beat 0 lives in the low bits.
module c2_line_serdes
    import c2_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                shift_out,
    input  logic                shift_in,
    input  logic [LINE_W-1:0]   load_data,
    input  logic [BUS_SIZE-1:0] beat_in,
    output logic [BUS_SIZE-1:0] beat_out,
    output logic [LINE_W-1:0]   line_shifted,
    output logic [BEAT_W-1:0]   beat_cnt
);

    logic [LINE_W-1:0] line_q;

    assign beat_out     = line_q[BUS_SIZE-1:0];
    assign line_shifted = {beat_in, line_q[LINE_W-1:BUS_SIZE]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_q   <= '0;
            beat_cnt <= '0;
        end else if (load) begin
            line_q   <= load_data;
            beat_cnt <= '0;
        end else if (shift_out) begin
            line_q   <= {{BUS_SIZE{1'b0}}, line_q[LINE_W-1:BUS_SIZE]};
            beat_cnt <= beat_cnt + 1'b1;
        end else if (shift_in) begin
            line_q   <= line_shifted;
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/c2_initiator.sv
// c2_initiator: cache-side C2 bus master, one whole-line read/write per request.
// Define C2_TIMEOUT_EN to add the response watchdog (resp_err on expiry).
module c2_initiator
    import c2_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic                   req_write,
    input  logic [LINE_ADDR_W-1:0] req_addr,
    input  logic [LINE_W-1:0]      req_wdata,
    output logic                   req_ready,
    output logic                   resp_valid,
    output logic [LINE_W-1:0]      resp_rdata,
    output logic                   resp_err,
    output logic [LINE_ADDR_W-1:0] c2_addr,
    output logic [1:0]             c2_cmd_out,
    output logic                   c2_cmd_oe,
    input  logic [1:0]             c2_cmd_in,
    output logic [BUS_SIZE-1:0]    c2_data_out,
    output logic                   c2_data_oe,
    input  logic [BUS_SIZE-1:0]    c2_data_in
);

    c2_state_e              state_q, state_d;
    logic [LINE_ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0]      rdata_q;
    logic                   load, shift_out, shift_in;
    logic [BUS_SIZE-1:0]    beat_out;
    logic [LINE_W-1:0]      line_shifted;
    logic [BEAT_W-1:0]      beat_cnt;
    logic                   rsp, last_beat, to_fire;

    assign rsp       = (c2_cmd_in == C2_RESPONSE);
    assign last_beat = (beat_cnt == BEAT_W'(BEATS - 1));

    c2_line_serdes u_serdes (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .shift_out    (shift_out),
        .shift_in     (shift_in),
        .load_data    (req_wdata),
        .beat_in      (c2_data_in),
        .beat_out     (beat_out),
        .line_shifted (line_shifted),
        .beat_cnt     (beat_cnt)
    );

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        shift_out = 1'b0;
        shift_in  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    load    = 1'b1;
                    state_d = req_write ? S_WR_BEAT : S_RD_CMD;
                end
            end
            S_WR_BEAT: begin
                shift_out = 1'b1;
                if (last_beat) state_d = S_WAIT_WACK;
            end
            S_WAIT_WACK: begin
                if (rsp || to_fire) state_d = S_DONE;
            end
            S_RD_CMD: state_d = S_WAIT_RDATA;
            S_WAIT_RDATA: begin
                if (rsp) begin
                    shift_in = 1'b1;
                    if (last_beat) state_d = S_DONE;
                end else if (to_fire) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus drive decodes straight from state so reset drops oe at once.
    always_comb begin
        c2_cmd_out  = C2_NOP;
        c2_cmd_oe   = 1'b0;
        c2_data_out = '0;
        c2_data_oe  = 1'b0;
        unique case (1'b1)
            (state_q == S_WR_BEAT): begin
                c2_cmd_out  = C2_WRITE;
                c2_cmd_oe   = 1'b1;
                c2_data_out = beat_out;
                c2_data_oe  = 1'b1;
            end
            (state_q == S_RD_CMD): begin
                c2_cmd_out = C2_READ;
                c2_cmd_oe  = 1'b1;
            end
            default: ;
        endcase
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_DONE);
    assign resp_rdata = rdata_q;
    assign c2_addr    = (state_q == S_IDLE) ? '0 : addr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) addr_q <= req_addr;
            if (shift_in && last_beat) rdata_q <= line_shifted;
            else if (to_fire) rdata_q <= '0;
        end
    end

`ifdef C2_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q;
    logic            err_q;
    logic            waiting;

    assign waiting  = (state_q == S_WAIT_WACK) || (state_q == S_WAIT_RDATA);
    assign to_fire  = waiting && !rsp && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign resp_err = (state_q == S_DONE) && err_q;

    // Count only silent wait cycles; any RESPONSE restarts the window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (!waiting || rsp) wd_q <= '0;
            else                 wd_q <= wd_q + 1'b1;
            if (waiting) err_q <= to_fire;
        end
    end
`else
    assign to_fire  = 1'b0;
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_c2_initiator.sv
// tb_c2_initiator: randomized transactions against a transaction-level
// model of the C2 initiator (beat order, latency, watchdog expiry).
module tb_c2_initiator;

    localparam int TMO = 64;
`ifdef C2_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid, req_write;
    logic [14:0]  req_addr;
    logic [127:0] req_wdata;
    logic         req_ready, resp_valid, resp_err;
    logic [127:0] resp_rdata;
    logic [14:0]  c2_addr;
    logic [1:0]   c2_cmd_out, c2_cmd_in;
    logic         c2_cmd_oe, c2_data_oe;
    logic [15:0]  c2_data_out, c2_data_in;

    int           checks = 0;
    int           errors = 0;
    logic [127:0] m_rdata;
    logic [15:0]  rd_beats[8];
    int           rd_gaps[8];

    c2_initiator dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .c2_addr     (c2_addr),
        .c2_cmd_out  (c2_cmd_out),
        .c2_cmd_oe   (c2_cmd_oe),
        .c2_cmd_in   (c2_cmd_in),
        .c2_data_out (c2_data_out),
        .c2_data_oe  (c2_data_oe),
        .c2_data_in  (c2_data_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] idle_cmd();
        case ($urandom_range(0, 2))
            0:       return 2'd0;
            1:       return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    task automatic check_idle();
        chk("idle_ready", req_ready, 1);
        chk("idle_rv", resp_valid, 0);
        chk("idle_addr", c2_addr, 0);
        chk("idle_oe", {c2_cmd_oe, c2_data_oe}, 0);
    endtask

    task automatic check_wait(input logic [14:0] a);
        chk("wait_oe", {c2_cmd_oe, c2_data_oe}, 0);
        chk("wait_rv", resp_valid, 0);
        chk("wait_ready", req_ready, 0);
        chk("wait_addr", c2_addr, a);
    endtask

    task automatic check_done(input logic [14:0] a, input bit err);
        chk("done_rv", resp_valid, 1);
        chk("done_err", resp_err, err);
        chk("done_rdata", resp_rdata, m_rdata);
        chk("done_ready", req_ready, 0);
        chk("done_addr", c2_addr, a);
        chk("done_oe", {c2_cmd_oe, c2_data_oe}, 0);
    endtask

    task automatic do_write(input logic [14:0] a, input logic [127:0] d,
                            input int dly);
        bit to;
        int n;
        @(negedge clk);
        check_idle();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = a;
        req_wdata = d;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_addr  = 15'($urandom);
            req_wdata = {4{$urandom}};
            chk("wr_cmd", c2_cmd_out, 3);
            chk("wr_oe", {c2_cmd_oe, c2_data_oe}, 2'b11);
            chk("wr_beat", c2_data_out, d[16*k +: 16]);
            chk("wr_addr", c2_addr, a);
            chk("wr_rv", resp_valid, 0);
            c2_cmd_in  = 2'($urandom);
            c2_data_in = 16'($urandom);
        end
        to = TO_EN && (dly >= TMO);
        n  = to ? TMO : dly;
        for (int g = 0; g < n; g++) begin
            @(negedge clk);
            check_wait(a);
            c2_cmd_in = idle_cmd();
        end
        if (!to) begin
            @(negedge clk);
            check_wait(a);
            c2_cmd_in = 2'd1;
        end else begin
            m_rdata = '0;
        end
        @(negedge clk);
        c2_cmd_in = idle_cmd();
        check_done(a, to);
    endtask

    task automatic do_read(input logic [14:0] a);
        logic [127:0] line;
        bit           to;
        int           n;
        @(negedge clk);
        check_idle();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = a;
        req_wdata = {4{$urandom}};
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 15'($urandom);
        chk("rd_cmd", c2_cmd_out, 2);
        chk("rd_oe", {c2_cmd_oe, c2_data_oe}, 2'b10);
        chk("rd_addr", c2_addr, a);
        chk("rd_rv", resp_valid, 0);
        c2_cmd_in  = 2'($urandom);
        c2_data_in = 16'($urandom);
        line = '0;
        to   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n = (TO_EN && rd_gaps[k] >= TMO) ? TMO : rd_gaps[k];
            for (int g = 0; g < n; g++) begin
                @(negedge clk);
                check_wait(a);
                c2_cmd_in  = idle_cmd();
                c2_data_in = 16'($urandom);
            end
            if (TO_EN && rd_gaps[k] >= TMO) begin
                to = 1'b1;
                break;
            end
            @(negedge clk);
            check_wait(a);
            c2_cmd_in  = 2'd1;
            c2_data_in = rd_beats[k];
            line[16*k +: 16] = rd_beats[k];
        end
        m_rdata = to ? '0 : line;
        @(negedge clk);
        c2_cmd_in  = idle_cmd();
        c2_data_in = 16'($urandom);
        check_done(a, to);
    endtask

    task automatic do_write_reset(input logic [14:0] a, input logic [127:0] d);
        @(negedge clk);
        check_idle();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = a;
        req_wdata = d;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            chk("rst_beat", c2_data_out, d[16*k +: 16]);
        end
        reset = 1'b1;
        #1;
        chk("rst_oe_async", {c2_cmd_oe, c2_data_oe}, 0);
        chk("rst_ready_async", req_ready, 1);
        m_rdata = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("rst_no_rv", resp_valid, 0);
            chk("rst_ready", req_ready, 1);
            chk("rst_rdata", resp_rdata, m_rdata);
            c2_cmd_in = 2'($urandom);
        end
    endtask

    task automatic set_read(input bit seq);
        for (int k = 0; k < 8; k++) begin
            rd_beats[k] = seq ? 16'((k + 1) * 16'h1111) : 16'($urandom);
            rd_gaps[k]  = seq ? 0 : $urandom_range(0, 3);
        end
    endtask

    initial begin
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        c2_cmd_in  = 2'd0;
        c2_data_in = '0;
        m_rdata    = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_rv", resp_valid, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_err", resp_err, 0);
        chk("rst_addr", c2_addr, 0);
        chk("rst_cmd", c2_cmd_out, 0);
        chk("rst_data", c2_data_out, 0);
        chk("rst_oe", {c2_cmd_oe, c2_data_oe}, 0);
        reset = 1'b0;

        do_write(15'h0012, {8{16'h00FF}}, 3);

        set_read(1'b1);
        do_read(15'h0034);
        chk("rd_line_const", resp_rdata,
            128'h8888_7777_6666_5555_4444_3333_2222_1111);

        set_read(1'b1);
        rd_gaps[4] = 3;
        do_read(15'h7FFF);

        do_write(15'h0001, {4{$urandom}}, 0);

        do_write_reset(15'h0055, {4{$urandom}});

        set_read(1'b0);
        rd_gaps[0] = 63;
        rd_gaps[5] = 63;
        do_read(15'h0100);

        do_write(15'h0222, {4{$urandom}}, 200);

        set_read(1'b0);
        rd_gaps[2] = 70;
        do_read(15'h0333);

        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                do_write(15'($urandom), {4{$urandom}}, $urandom_range(0, 6));
            end else begin
                set_read(1'b0);
                do_read(15'($urandom));
            end
        end

        @(negedge clk);
        check_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/c2_initiator.md
# c2_initiator

Cache-side master for the C2 memory bus. Accepts one whole-line read or write request from the cache controller and serializes it into C2 READ/WRITE command and data beats. It waits for the memory responder's RESPONSE, collects read beats into a full line, and returns a single-cycle completion to the cache. It sits between the cache controller and the top-level C2 tristate drivers; the memory model is the responder on the other end.

## Interface
- MEM_ADDR_SIZE, 19: byte address width.
- CACHE_OFFSET_SIZE, 4: line offset bits. The line address is MEM_ADDR_SIZE-CACHE_OFFSET_SIZE = 15 bits.
- BUS_SIZE, 16: C2 data bus width.
- CACHE_LINE_SIZE, 16: line size in bytes. BEATS = CACHE_LINE_SIZE*8/BUS_SIZE = 8.
- TIMEOUT_CYCLES, 64: response watchdog limit. Used only with C2_TIMEOUT_EN.
- clk, in, 1: clock.
- reset, in, 1: reset, asynchronous, active-high.
- req_valid, in, 1: cache request present.
- req_write, in, 1: 1 = write line, 0 = read line.
- req_addr, in, 15: line address.
- req_wdata, in, 128: write line. Byte 0 is in bits [7:0].
- req_ready, out, 1: high only in IDLE.
- resp_valid, out, 1: one-cycle completion pulse.
- resp_rdata, out, 128: read line. Valid with resp_valid on reads.
- resp_err, out, 1: timeout flag. Valid with resp_valid.
- c2_addr, out, 15: bus line address.
- c2_cmd_out, out, 2 / c2_cmd_oe, out, 1 / c2_cmd_in, in, 2: command bus split into drive value, enable and sampled value.
- c2_data_out, out, 16 / c2_data_oe, out, 1 / c2_data_in, in, 16: data bus split into drive value, enable and sampled value.

## Operation
- Commands: NOP = 0, RESPONSE = 1, READ = 2, WRITE = 3.
- States: IDLE, WR_BEAT, WAIT_WACK, RD_CMD, WAIT_RDATA, DONE.
- IDLE:
  - req_ready = 1; both oe = 0.
  - On req_valid, latch addr, write flag and wdata. Go to WR_BEAT if req_write, else RD_CMD.
- WR_BEAT:
  - Drive cmd = WRITE, c2_addr, and data = beat k = wdata[16k +: 16], for k = 0..7, one beat per cycle; both oe = 1.
  - After beat 7, go to WAIT_WACK.
- WAIT_WACK:
  - Both oe = 0.
  - The first cycle with c2_cmd_in == RESPONSE goes to DONE. Other values are ignored.
- RD_CMD:
  - One cycle: cmd = READ, c2_addr driven, cmd_oe = 1, data_oe = 0. Then go to WAIT_RDATA.
- WAIT_RDATA:
  - Both oe = 0.
  - Each cycle with c2_cmd_in == RESPONSE captures c2_data_in into beat k, then k++. Non-RESPONSE cycles stall without capturing.
  - After beat 7 is captured, go to DONE.
- DONE:
  - resp_valid = 1 for one cycle. resp_rdata holds the assembled line (reads) and is unchanged on writes.
  - Then go to IDLE.
- c2_addr holds the latched address from RD_CMD/WR_BEAT until IDLE. It is 0 otherwise.
- The beat counter is 3 bits and wraps naturally. The state decides termination, not the wrap.
- A new request is not accepted in DONE. Back-to-back requests therefore start at best 1 cycle after resp_valid.

## Timing
- Reset values:
  - state IDLE; req_ready 1; resp_valid 0; resp_rdata 0; resp_err 0.
  - c2_addr 0; c2_cmd_out NOP; c2_data_out 0; both oe 0.
- Reset mid-transaction drops both oe immediately (asynchronously). No resp_valid is issued and the in-flight request is lost.
- Write: accepted on edge T. Beats are driven in cycles T+1..T+8. RESPONSE sampled at edge N gives resp_valid in cycle N+1. The minimum is resp_valid at T+10.
- Read: READ driven in cycle T+1. The earliest capture is at edge T+2. The last beat at edge M gives resp_valid in cycle M+1. The minimum is T+10.
- RESPONSE arriving while the block drives the command bus is ignored.

## Configuration
- C2_TIMEOUT_EN defined:
  - A watchdog counter clears on entry to WAIT_WACK/WAIT_RDATA and on each captured beat.
  - If it reaches TIMEOUT_CYCLES without a RESPONSE, go to DONE with resp_err = 1 and resp_rdata = 0.
  - resp_err = 0 on normal completion.
- C2_TIMEOUT_EN undefined: there is no counter, resp_err is tied to 0, and the block waits indefinitely.

## Structure
- Package c2_pkg holds:
  - the command enum (NOP/RESPONSE/READ/WRITE);
  - the state enum;
  - BEATS and line-address width derived constants.
- Sub-module c2_line_serdes: a 128-bit shift register with load, shift-out (write) and shift-in (read) modes, plus the beat counter.

## Test plan
- Write: addr 0x0012, wdata 0x00FF repeated across the line. Expect WRITE on 8 cycles with beats 0x00FF and c2_addr 0x0012. A RESPONSE 3 cycles later gives resp_valid with resp_err 0.
- Read: responder returns beats 0x1111..0x8888 contiguously. Expect resp_rdata = 0x8888777766665555444433332222 1111 and resp_valid one cycle after the last beat.
- Read with NOP gaps between beats 3 and 4: expect the line to be assembled identically and resp_valid delayed by the gap length.
- Reset asserted during beat 5 of a write: expect both oe 0 at once, req_ready 1 after release, and no resp_valid.
- With C2_TIMEOUT_EN and TIMEOUT_CYCLES = 64, no RESPONSE: expect resp_valid with resp_err 1 and resp_rdata 0 after 64 wait cycles.
- Without C2_TIMEOUT_EN, same stimulus: expect no resp_valid for 200 cycles, then a late RESPONSE completes with resp_err 0.
